alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//   Shares the single combinational execute ALU between NUM_REQ requesters
//   (req 0 = EX-stage issue, req 1 = branch-compare unit).
//   - Round-robin grant; drives the ALU operand/control bus for the granted request.
//   - Captures ALUout/Zero into a one-entry response buffer.
//   - Returns the result tagged with the requester id over a valid/ready handshake.
// PARAMETERS
//   DATA_WIDTH  32  operand/result width
//   NUM_REQ     2   number of requesters (>=2)
//   ID_W        $clog2(NUM_REQ)  response tag width (localparam)
// PORTS
//   clk          in   1                  clock, all state on rising edge
//   rst_n        in   1                  async active-low reset
//   req_valid    in   NUM_REQ            request pending, per requester
//   req_ready    out  NUM_REQ            one-hot grant/accept this cycle
//   req_op1      in   NUM_REQ*DATA_WIDTH operand 1, requester i at [i*DW +: DW]
//   req_src      in   NUM_REQ            1 = use imm as operand 2
//   req_op2      in   NUM_REQ*DATA_WIDTH register operand 2
//   req_imm      in   NUM_REQ*DATA_WIDTH immediate operand
//   req_ctrl     in   NUM_REQ*3          ALU control code
//   alu_op1      out  DATA_WIDTH         to ALU ALUop1
//   alu_src      out  1                  to ALU ALUsrc
//   alu_reg_op2  out  DATA_WIDTH         to ALU regOp2
//   alu_imm_op   out  DATA_WIDTH         to ALU ImmOp
//   alu_ctrl     out  3                  to ALU ALUctrl
//   alu_out      in   DATA_WIDTH         from ALU ALUout
//   alu_zero     in   1                  from ALU Zero
//   rsp_valid    out  1                  response buffer full
//   rsp_ready    in   1                  consumer accepts response
//   rsp_id       out  ID_W               requester that issued the op
//   rsp_data     out  DATA_WIDTH         captured ALU result
//   rsp_zero     out  1                  captured zero flag
// BEHAVIOUR
//   - Reset (async, rst_n=0): rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0,
//     RR pointer=0, FSM=EMPTY. req_ready=0 while rst_n=0.
//   - FSM EMPTY: buffer free.
//     - Any req_valid: grant one, go FULL.
//     - No req_valid: stay EMPTY.
//   - FSM FULL: rsp_valid=1.
//     - rsp_ready=1 with a req_valid: drain and grant new in the same cycle, stay FULL.
//     - rsp_ready=1 without req_valid: go EMPTY.
//     - rsp_ready=0: hold all rsp_* stable, no grant.
//   - can_issue = (state==EMPTY) | rsp_ready. req_ready[g]=1 only for granted g,
//     only when can_issue & req_valid[g]. At most one bit of req_ready is set.
//   - Grant: round-robin starting at pointer. Winner g → pointer=(g+1) mod NUM_REQ.
//     Pointer is unchanged when there is no grant.
//   - ALU bus is combinational from the granted request. With no grant the bus
//     drives all-zero, ctrl=3'b000.
//   - Latency: grant in cycle N → rsp_valid=1 in cycle N+1. Throughput 1 op/cycle
//     when rsp_ready is held high.
//   - Capture: rsp_data<=alu_out. rsp_zero<=alu_zero only if ctrl==ALU_SUB, else 0
//     (ALU Zero is defined only for SUB).
//   - Width: no extension or truncation; ops, result and imm are all DATA_WIDTH.
//   - A requester must hold its req_* stable until req_ready. Deasserting valid
//     without a grant is legal.
// STRUCTURE
//   - alu_pkg: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_CTRL_W=3, typedef alu_req_t
//     {op1, src, op2, imm, ctrl}, typedef arb_state_e {EMPTY, FULL}.
//   - Sub-module rr_arbiter #(N): inputs req, ptr; outputs one-hot gnt, gnt_idx.
//     Purely combinational; pointer register stays in the parent.
// TESTING
//   - Reset: rst_n low mid-FULL with rsp_valid=1 → all rsp_* =0, req_ready=0
//     immediately, no clock needed.
//   - Single ADD: req0 op1=5, src=1, imm=7, ctrl=000 → req_ready=01; next cycle
//     rsp_valid=1, rsp_id=0, rsp_data=12, rsp_zero=0.
//   - SUB zero: req1 op1=9, op2=9, src=0, ctrl=001 → rsp_id=1, rsp_data=0, rsp_zero=1.
//     Same operands with ctrl=000 → rsp_zero=0.
//   - Contention: both valid every cycle, rsp_ready=1 → grants alternate 01,10,01,10.
//     rsp_id sequence 0,1,0,1 (pointer from reset = 0).
//   - Backpressure: rsp_ready=0 for 3 cycles while FULL → no req_ready, rsp_* stable.
//     On rsp_ready=1 the drain and new grant happen in the same cycle.
//   - Drain to empty: FULL, no req_valid, rsp_ready=1 → next cycle rsp_valid=0.
//     ALU bus drives zeros.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-ALU sharing arbiter.
package alu_pkg;

    localparam int ALU_CTRL_W = 3;
    localparam int ALU_DATA_W = 32;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] op1;
        logic                  src;
        logic [ALU_DATA_W-1:0] op2;
        logic [ALU_DATA_W-1:0] imm;
        logic [ALU_CTRL_W-1:0] ctrl;
    } alu_req_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr wins.
module rr_arbiter #(
    parameter  int N     = 2,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] cand_s;
    logic             found_s;

    // Scan candidates ptr, ptr+1, ... modulo N and latch the first requester.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found_s = 1'b0;
        sum_s   = '0;
        cand_s  = '0;
        for (int i = 0; i < N; i++) begin
            sum_s = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum_s >= (IDX_W+1)'(N)) begin
                cand_s = IDX_W'(sum_s - (IDX_W+1)'(N));
            end else begin
                cand_s = IDX_W'(sum_s);
            end
            if (!found_s && req[cand_s]) begin
                found_s      = 1'b1;
                gnt[cand_s]  = 1'b1;
                gnt_idx      = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters; results return
// through a one-entry buffer tagged with the issuing requester id.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter  int DATA_WIDTH = ALU_DATA_W,
    parameter  int NUM_REQ    = 2,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_op1,
    input  logic [NUM_REQ-1:0]               req_src,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_op2,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_imm,
    input  logic [NUM_REQ*ALU_CTRL_W-1:0]    req_ctrl,
    output logic [DATA_WIDTH-1:0]            alu_op1,
    output logic                             alu_src,
    output logic [DATA_WIDTH-1:0]            alu_reg_op2,
    output logic [DATA_WIDTH-1:0]            alu_imm_op,
    output logic [ALU_CTRL_W-1:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0]            alu_out,
    input  logic                             alu_zero,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [ID_W-1:0]                  rsp_id,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic                             rsp_zero
);

    arb_state_e            state_r;
    arb_state_e            state_nxt_s;
    logic [ID_W-1:0]       ptr_r;
    logic                  can_issue_s;
    logic [NUM_REQ-1:0]    arb_req_s;
    logic [NUM_REQ-1:0]    gnt_s;
    logic [ID_W-1:0]       gnt_idx_s;
    logic                  grant_s;

    logic [DATA_WIDTH-1:0] op1_s  [NUM_REQ];
    logic [DATA_WIDTH-1:0] op2_s  [NUM_REQ];
    logic [DATA_WIDTH-1:0] imm_s  [NUM_REQ];
    logic [ALU_CTRL_W-1:0] ctrl_s [NUM_REQ];

    // Split the flat request buses into per-requester fields.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            op1_s[i]  = req_op1[i*DATA_WIDTH +: DATA_WIDTH];
            op2_s[i]  = req_op2[i*DATA_WIDTH +: DATA_WIDTH];
            imm_s[i]  = req_imm[i*DATA_WIDTH +: DATA_WIDTH];
            ctrl_s[i] = req_ctrl[i*ALU_CTRL_W +: ALU_CTRL_W];
        end
    end

    // The buffer slot is free when empty or when it drains this cycle;
    // rst_n gates grants so nothing is accepted while reset is held.
    assign can_issue_s = (state_r == EMPTY) | rsp_ready;
    assign arb_req_s   = req_valid & {NUM_REQ{can_issue_s & rst_n}};

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req     (arb_req_s),
        .ptr     (ptr_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    assign grant_s   = |gnt_s;
    assign req_ready = gnt_s;
    assign rsp_valid = (state_r == FULL);

    // Drive the shared ALU from the granted request, zeros when idle.
    always_comb begin
        alu_op1     = '0;
        alu_src     = 1'b0;
        alu_reg_op2 = '0;
        alu_imm_op  = '0;
        alu_ctrl    = ALU_ADD;
        if (grant_s) begin
            alu_op1     = op1_s[gnt_idx_s];
            alu_src     = req_src[gnt_idx_s];
            alu_reg_op2 = op2_s[gnt_idx_s];
            alu_imm_op  = imm_s[gnt_idx_s];
            alu_ctrl    = ctrl_s[gnt_idx_s];
        end else begin
            alu_ctrl    = ALU_ADD;
        end
    end

    // Buffer occupancy: a grant always refills, a drain without grant empties.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            EMPTY: begin
                if (grant_s) begin
                    state_nxt_s = FULL;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            FULL: begin
                if (grant_s) begin
                    state_nxt_s = FULL;
                end else if (rsp_ready) begin
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            default: state_nxt_s = EMPTY;
        endcase
    end

    // State, round-robin pointer and response buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= EMPTY;
            ptr_r    <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (grant_s) begin
                ptr_r    <= (gnt_idx_s == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx_s + ID_W'(1);
                rsp_id   <= gnt_idx_s;
                rsp_data <= alu_out;
                // Zero is only meaningful for subtraction.
                rsp_zero <= (alu_ctrl == ALU_SUB) ? alu_zero : 1'b0;
            end else begin
                ptr_r    <= ptr_r;
                rsp_id   <= rsp_id;
                rsp_data <= rsp_data;
                rsp_zero <= rsp_zero;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model of the arbiter and a behavioural ALU.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_op1;
    logic [1:0]  req_src;
    logic [63:0] req_op2;
    logic [63:0] req_imm;
    logic [5:0]  req_ctrl;
    logic [31:0] alu_op1;
    logic        alu_src;
    logic [31:0] alu_reg_op2;
    logic [31:0] alu_imm_op;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_zero;

    alu_req_t    rq [2];
    logic [1:0]  vld;

    int checks;
    int failures;

    // Transaction-level model state
    logic        m_full;
    int          m_ptr;
    logic [0:0]  m_id;
    logic [31:0] m_data;
    logic        m_zero;

    alu_share_arbiter #(.DATA_WIDTH(32), .NUM_REQ(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op1     (req_op1),
        .req_src     (req_src),
        .req_op2     (req_op2),
        .req_imm     (req_imm),
        .req_ctrl    (req_ctrl),
        .alu_op1     (alu_op1),
        .alu_src     (alu_src),
        .alu_reg_op2 (alu_reg_op2),
        .alu_imm_op  (alu_imm_op),
        .alu_ctrl    (alu_ctrl),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_zero    (rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [2:0] c);
        case (c)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return (a < b) ? 32'd1 : 32'd0;
            default: return a;
        endcase
    endfunction

    function automatic logic [31:0] ref_result(alu_req_t r);
        return alu_fn(r.op1, r.src ? r.imm : r.op2, r.ctrl);
    endfunction

    // Behavioural ALU: Zero reflects the result for every op.
    assign alu_out  = alu_fn(alu_op1, alu_src ? alu_imm_op : alu_reg_op2, alu_ctrl);
    assign alu_zero = (alu_out == 32'd0);

    always_comb begin
        req_valid = vld;
        req_op1   = '0;
        req_op2   = '0;
        req_imm   = '0;
        req_src   = '0;
        req_ctrl  = '0;
        for (int i = 0; i < 2; i++) begin
            req_op1[i*32 +: 32] = rq[i].op1;
            req_op2[i*32 +: 32] = rq[i].op2;
            req_imm[i*32 +: 32] = rq[i].imm;
            req_src[i]          = rq[i].src;
            req_ctrl[i*3 +: 3]  = rq[i].ctrl;
        end
    end

    task automatic set_req(int i, logic [31:0] op1, logic src, logic [31:0] op2,
                           logic [31:0] imm, logic [2:0] ctrl);
        rq[i].op1  = op1;
        rq[i].src  = src;
        rq[i].op2  = op2;
        rq[i].imm  = imm;
        rq[i].ctrl = ctrl;
    endtask

    task automatic do_reset();
        vld       = 2'b00;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vld       = 2'b00;
        rsp_ready = 1'b0;
        set_req(0, 32'd0, 1'b0, 32'd0, 32'd0, ALU_ADD);
        set_req(1, 32'd0, 1'b0, 32'd0, 32'd0, ALU_ADD);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_id !== 1'b0 || rsp_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_init got v=%b id=%0d d=%0h z=%b expected all zero",
                     rsp_valid, rsp_id, rsp_data, rsp_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Fill the buffer from requester 1 with backpressure held.
        set_req(1, 32'd3, 1'b0, 32'd4, 32'd0, ALU_ADD);
        vld = 2'b10;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b10) begin
            failures++;
            $display("FAIL reset_fill_grant got=%b expected=%b", req_ready, 2'b10);
        end
        @(posedge clk);
        #1;
        vld = 2'b00;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'd7) begin
            failures++;
            $display("FAIL reset_fill_rsp got v=%b id=%0d d=%0d expected v=1 id=1 d=7",
                     rsp_valid, rsp_id, rsp_data);
        end
        vld = 2'b11;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_id !== 1'b0 || rsp_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_midfull got v=%b id=%0d d=%0h z=%b expected all zero",
                     rsp_valid, rsp_id, rsp_data, rsp_zero);
        end
        checks++;
        if (req_ready !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready got=%b expected=00", req_ready);
        end
        vld = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_add();
        set_req(0, 32'd5, 1'b1, $urandom, 32'd7, ALU_ADD);
        vld       = 2'b01;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL add_grant got=%b expected=01", req_ready);
        end
        checks++;
        if (alu_op1 !== 32'd5 || alu_src !== 1'b1 || alu_imm_op !== 32'd7 || alu_ctrl !== ALU_ADD) begin
            failures++;
            $display("FAIL add_bus got op1=%0d src=%b imm=%0d ctrl=%b expected 5 1 7 000",
                     alu_op1, alu_src, alu_imm_op, alu_ctrl);
        end
        @(posedge clk);
        #1;
        vld = 2'b00;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd12 || rsp_zero !== 1'b0) begin
            failures++;
            $display("FAIL add_rsp got v=%b id=%0d d=%0d z=%b expected 1 0 12 0",
                     rsp_valid, rsp_id, rsp_data, rsp_zero);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sub_zero();
        // Pointer is now 1 after the previous grant to requester 0.
        set_req(1, 32'd9, 1'b0, 32'd9, $urandom, ALU_SUB);
        vld       = 2'b10;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b10) begin
            failures++;
            $display("FAIL sub_grant got=%b expected=10", req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rsp_id !== 1'b1 || rsp_data !== 32'd0 || rsp_zero !== 1'b1) begin
            failures++;
            $display("FAIL sub_zero got id=%0d d=%0d z=%b expected 1 0 1", rsp_id, rsp_data, rsp_zero);
        end
        set_req(1, 32'd9, 1'b0, 32'd9, 32'd0, ALU_ADD);
        @(posedge clk);
        #1;
        checks++;
        if (rsp_id !== 1'b1 || rsp_data !== 32'd18 || rsp_zero !== 1'b0) begin
            failures++;
            $display("FAIL add_nozero got id=%0d d=%0d z=%b expected 1 18 0", rsp_id, rsp_data, rsp_zero);
        end
        // ADD producing zero: ALU Zero is high but must not be captured.
        set_req(1, 32'd5, 1'b0, 32'hFFFF_FFFB, 32'd0, ALU_ADD);
        @(posedge clk);
        #1;
        checks++;
        if (rsp_data !== 32'd0 || rsp_zero !== 1'b0) begin
            failures++;
            $display("FAIL add_zero_masked got d=%0d z=%b expected 0 0", rsp_data, rsp_zero);
        end
        set_req(1, 32'd9, 1'b0, 32'd4, 32'd0, ALU_SUB);
        @(posedge clk);
        #1;
        vld = 2'b00;
        checks++;
        if (rsp_data !== 32'd5 || rsp_zero !== 1'b0) begin
            failures++;
            $display("FAIL sub_nonzero got d=%0d z=%b expected 5 0", rsp_data, rsp_zero);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_contention();
        logic [1:0] exp_g;
        do_reset();
        set_req(0, 32'd100, 1'b1, 32'd0, 32'd1, ALU_SUB);
        set_req(1, 32'd3, 1'b0, 32'd4, 32'd0, ALU_ADD);
        vld       = 2'b11;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            checks++;
            if (req_ready !== exp_g) begin
                failures++;
                $display("FAIL contention_grant[%0d] got=%b expected=%b", k, req_ready, exp_g);
            end
            @(posedge clk);
            #1;
            checks++;
            if (rsp_id !== 1'(k % 2) || rsp_data !== ((k % 2 == 0) ? 32'd99 : 32'd7)) begin
                failures++;
                $display("FAIL contention_rsp[%0d] got id=%0d d=%0d", k, rsp_id, rsp_data);
            end
        end
    endtask

    task automatic test_backpressure();
        // Buffer holds requester 1's result (7); both still requesting.
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 2'b00 || rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'd7) begin
                failures++;
                $display("FAIL backpressure[%0d] got rdy=%b v=%b id=%0d d=%0d expected 00 1 1 7",
                         k, req_ready, rsp_valid, rsp_id, rsp_data);
            end
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL bp_release_grant got=%b expected=01", req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd99) begin
            failures++;
            $display("FAIL bp_release_rsp got v=%b id=%0d d=%0d expected 1 0 99",
                     rsp_valid, rsp_id, rsp_data);
        end
    endtask

    task automatic test_drain();
        vld       = 2'b00;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00) begin
            failures++;
            $display("FAIL drain_ready got=%b expected=00", req_ready);
        end
        checks++;
        if (alu_op1 !== 32'd0 || alu_reg_op2 !== 32'd0 || alu_imm_op !== 32'd0 ||
            alu_src !== 1'b0 || alu_ctrl !== 3'b000) begin
            failures++;
            $display("FAIL drain_bus got op1=%0h op2=%0h imm=%0h src=%b ctrl=%b expected zeros",
                     alu_op1, alu_reg_op2, alu_imm_op, alu_src, alu_ctrl);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty got v=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_random();
        int         g;
        int         idx;
        logic [1:0] exp_r;
        do_reset();
        m_full = 1'b0;
        m_ptr  = 0;
        m_id   = 1'b0;
        m_data = 32'd0;
        m_zero = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (vld[i]) begin
                    if ($urandom_range(0, 3) == 0) vld[i] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    set_req(i, $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom,
                            3'($urandom_range(0, 5)));
                    if ($urandom_range(0, 3) == 0) rq[i].op2 = rq[i].op1;
                    vld[i] = 1'b1;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            g = -1;
            if (!m_full || rsp_ready) begin
                for (int k = 0; k < 2; k++) begin
                    idx = (m_ptr + k) % 2;
                    if (g < 0 && vld[idx]) g = idx;
                end
            end
            exp_r = 2'b00;
            if (g >= 0) exp_r[g] = 1'b1;
            checks++;
            if (req_ready !== exp_r) begin
                failures++;
                $display("FAIL rand_grant cyc=%0d got=%b expected=%b", cyc, req_ready, exp_r);
            end
            checks++;
            if (rsp_valid !== m_full ||
                (m_full && (rsp_id !== m_id || rsp_data !== m_data || rsp_zero !== m_zero))) begin
                failures++;
                $display("FAIL rand_rsp cyc=%0d got v=%b id=%0d d=%0h z=%b expected v=%b id=%0d d=%0h z=%b",
                         cyc, rsp_valid, rsp_id, rsp_data, rsp_zero, m_full, m_id, m_data, m_zero);
            end
            if (g >= 0) begin
                m_data = ref_result(rq[g]);
                m_zero = (rq[g].ctrl == ALU_SUB) && (m_data == 32'd0);
                m_id   = 1'(g);
                m_ptr  = (g + 1) % 2;
                m_full = 1'b1;
            end else if (m_full && rsp_ready) begin
                m_full = 1'b0;
            end
            @(posedge clk);
            #1;
            if (g >= 0) vld[g] = 1'b0;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        vld      = 2'b00;
        test_reset();
        test_single_add();
        test_sub_zero();
        test_contention();
        test_backpressure();
        test_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
